// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: widths, special opcodes, IF/ID word layout and FSM states.
package fetch_stage_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned FLAGS_W = 3;
  localparam int unsigned IFID_W  = FLAGS_W + INSTR_W + PC_W;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;
  localparam logic [3:0]         HALT_OP   = 4'hF;

  localparam int unsigned IFID_PC_LSB    = 0;
  localparam int unsigned IFID_INSTR_LSB = 16;
  localparam int unsigned IFID_FLAGS_LSB = 32;

  typedef enum logic [1:0] {
    StFetch,
    StDiscard,
    StHalt
  } fetch_state_e;

  function automatic logic [IFID_W-1:0] make_ifid(input logic [FLAGS_W-1:0] flags,
                                                  input logic [INSTR_W-1:0] instr,
                                                  input logic [PC_W-1:0]    pc_field);
    logic [IFID_W-1:0] w;
    w = '0;
    w[IFID_FLAGS_LSB +: FLAGS_W] = flags;
    w[IFID_INSTR_LSB +: INSTR_W] = instr;
    w[IFID_PC_LSB +: PC_W]       = pc_field;
    return w;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus: fetch side is master, memory is slave.
interface fetch_stage_if;

  logic                                 imem_rd;
  logic [fetch_stage_pkg::PC_W-1:0]     imem_addr;
  logic [fetch_stage_pkg::INSTR_W-1:0]  imem_data;
  logic                                 imem_valid;

  modport master (
    output imem_rd,
    output imem_addr,
    input  imem_data,
    input  imem_valid
  );

  modport slave (
    input  imem_rd,
    input  imem_addr,
    output imem_data,
    output imem_valid
  );

endinterface

// File: rtl/fetch_stage_fsm.sv
// Fetch control: tracks the outstanding imem request and decides PC update, bubble and IF/ID write.
module fetch_stage_fsm
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic            valid_i,
  input  logic            halt_op_i,
  input  logic [PC_W-1:0] pc_d_i,
  output logic            imem_rd_o,
  output logic [PC_W-1:0] req_addr_o,
  output logic            pc_load_o,
  output logic            pc_inc_o,
  output logic            bubble_o,
  output logic            ifid_wen_o,
  output logic            halted_o
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] req_addr_q, req_addr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StFetch;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    imem_rd_o  = 1'b0;
    pc_load_o  = 1'b0;
    pc_inc_o   = 1'b0;
    bubble_o   = 1'b1;
    ifid_wen_o = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        StFetch: begin
          imem_rd_o = 1'b1;
          if (branch_i) begin
            pc_load_o  = 1'b1;
            ifid_wen_o = 1'b1;
            // Redirect while the old read is still in flight: wait it out and drop it.
            if (!valid_i) state_d = StDiscard;
          end else if (valid_i && !stall_i) begin
            bubble_o   = 1'b0;
            ifid_wen_o = 1'b1;
            if (halt_op_i) state_d = StHalt;
            else           pc_inc_o = 1'b1;
          end else if (!valid_i) begin
            ifid_wen_o = !stall_i;
          end
        end
        StDiscard: begin
          imem_rd_o  = 1'b1;
          pc_load_o  = branch_i;
          ifid_wen_o = !stall_i || branch_i;
          if (valid_i) state_d = StFetch;
        end
        StHalt: begin
          if (branch_i) begin
            pc_load_o = 1'b1;
            state_d   = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  // Outside DISCARD the request address tracks the PC; in DISCARD it pins the abandoned read.
  always_comb begin
    req_addr_d = pc_d_i;
    if (state_d == StDiscard) req_addr_d = req_addr_q;
  end

  assign req_addr_o = req_addr_q;
  assign halted_o   = (state_q == StHalt);

endmodule

// File: rtl/fetch_stage.sv
// IF stage top: PC register, +2 adder and IF/ID word mux around the fetch control FSM.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_W-1:0]     branch_target,
  input  logic [FLAGS_W-1:0]  flags_in,
  fetch_stage_if.master       imem,
  output logic [IFID_W-1:0]   ifid_d,
  output logic                ifid_wen,
  output logic [PC_W-1:0]     pc,
  output logic                halted
);

  logic [PC_W-1:0] pc_q, pc_d, pc_plus2, req_addr;
  logic            pc_load, pc_inc, bubble, halt_op;

  assign pc_plus2 = pc_q + PC_W'(2);
  assign halt_op  = (imem.imem_data[INSTR_W-1 -: 4] == HALT_OP);

  always_comb begin
    pc_d = pc_q;
    if (pc_load)     pc_d = branch_target;
    else if (pc_inc) pc_d = pc_plus2;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  fetch_stage_fsm #(
    .RESET_PC (RESET_PC)
  ) u_fsm (
    .clk_i      (clk),
    .rst_i      (rst),
    .stall_i    (stall),
    .branch_i   (branch_taken),
    .valid_i    (imem.imem_valid),
    .halt_op_i  (halt_op),
    .pc_d_i     (pc_d),
    .imem_rd_o  (imem.imem_rd),
    .req_addr_o (req_addr),
    .pc_load_o  (pc_load),
    .pc_inc_o   (pc_inc),
    .bubble_o   (bubble),
    .ifid_wen_o (ifid_wen),
    .halted_o   (halted)
  );

  assign imem.imem_addr = req_addr;

  // Bubbles carry a zero PC field so later stages can tell them from real instructions.
  always_comb begin
    if (bubble) ifid_d = make_ifid(flags_in, NOP_INSTR, '0);
    else        ifid_d = make_ifid(flags_in, imem.imem_data, pc_plus2);
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios followed by randomized traffic.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken;
  logic [15:0] branch_target;
  logic [2:0]  flags_in;
  logic [34:0] ifid_d;
  logic        ifid_wen, halted;
  logic [15:0] pc;

  fetch_stage_if imem_bus ();

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .flags_in      (flags_in),
    .imem          (imem_bus),
    .ifid_d        (ifid_d),
    .ifid_wen      (ifid_wen),
    .pc            (pc),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [15:0] addr;
    bit          wen;
    logic [34:0] d;
    logic [15:0] pc;
    bit          halted;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model state, in terms of the architectural behaviour.
  logic [15:0] m_pc, m_req;
  bit          m_disc, m_halt;
  logic [15:0] mem [128];
  bit          mem_busy;
  int          mem_cnt;

  function automatic void check(string name, logic [34:0] act, logic [34:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // One clock cycle: drive inputs (and memory response), predict outputs, advance model.
  task automatic cycle(input bit r, input bit s, input bit b, input logic [15:0] t,
                       input int lat, input bit chk);
    exp_t        e;
    bit          v;
    bit          rd;
    logic [15:0] dat;
    logic [2:0]  f;
    f  = 3'($urandom);
    rd = !r && !m_halt;
    if (rd && !mem_busy) begin
      mem_busy = 1'b1;
      mem_cnt  = lat;
    end
    v   = rd && mem_busy && (mem_cnt == 0);
    dat = v ? mem[m_req[7:1]] : 16'($urandom);

    rst                 = r;
    stall               = s;
    branch_taken        = b;
    branch_target       = t;
    flags_in            = f;
    imem_bus.imem_valid = rd ? v : 1'($urandom);
    imem_bus.imem_data  = dat;

    e.rd     = rd;
    e.addr   = m_req;
    e.pc     = m_pc;
    e.halted = m_halt;
    e.wen    = 1'b0;
    e.d      = {f, 16'h0000, 16'h0000};

    if (r) begin
      m_pc = 16'h0000; m_req = 16'h0000; m_disc = 1'b0; m_halt = 1'b0;
    end else if (m_halt) begin
      if (b) begin
        m_pc = t; m_req = t; m_halt = 1'b0;
      end
    end else if (m_disc) begin
      e.wen = !s || b;
      if (b) m_pc = t;
      if (v) begin
        m_disc = 1'b0; m_req = m_pc;
      end
    end else if (b) begin
      e.wen = 1'b1;
      m_pc  = t;
      if (v) m_req = t;
      else   m_disc = 1'b1;
    end else if (v && !s) begin
      e.wen = 1'b1;
      e.d   = {f, dat, m_pc + 16'd2};
      if (dat[15:12] == 4'hF) m_halt = 1'b1;
      else begin
        m_pc = m_pc + 16'd2; m_req = m_pc;
      end
    end else if (!v) begin
      e.wen = !s;
    end

    if (r || v)        mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;

    if (chk) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT outputs mid-cycle against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("imem_rd", 35'(imem_bus.imem_rd), 35'(e.rd));
        if (e.rd) check("imem_addr", 35'(imem_bus.imem_addr), 35'(e.addr));
        check("ifid_wen", 35'(ifid_wen), 35'(e.wen));
        if (e.wen) check("ifid_d", ifid_d, e.d);
        check("pc", 35'(pc), 35'(e.pc));
        check("halted", 35'(halted), 35'(e.halted));
      end
    end
  end

  initial begin
    logic [15:0] tgt;
    for (int i = 0; i < 128; i++) mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    mem[5]  = 16'hF000;
    mem[40] = 16'hF123;
    m_pc = 16'h0000; m_req = 16'h0000; m_disc = 1'b0; m_halt = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0;

    cycle(1, 0, 0, 16'h0, 0, 0);
    cycle(1, 0, 0, 16'h0, 0, 1);
    // Zero-wait fetch, then a two-cycle stall at pc=4 and release.
    cycle(0, 0, 0, 16'h0, 0, 1);
    cycle(0, 0, 0, 16'h0, 0, 1);
    cycle(0, 1, 0, 16'h0, 0, 1);
    cycle(0, 1, 0, 16'h0, 0, 1);
    cycle(0, 0, 0, 16'h0, 0, 1);
    // Branch with stall at pc=6: branch wins.
    cycle(0, 1, 1, 16'h0040, 0, 1);
    cycle(0, 0, 0, 16'h0, 0, 1);
    // Slow memory: branch during the read at 0x0008 forces a discard.
    cycle(0, 0, 1, 16'h0008, 0, 1);
    cycle(0, 0, 1, 16'h0040, 3, 1);
    repeat (3) cycle(0, 0, 0, 16'h0, 0, 1);
    repeat (2) cycle(0, 0, 0, 16'h0, 0, 1);
    // HALT at 0x000A, released by a branch to 0x0020.
    cycle(0, 0, 1, 16'h000A, 0, 1);
    repeat (4) cycle(0, 0, 0, 16'h0, 0, 1);
    cycle(0, 0, 1, 16'h0020, 0, 1);
    repeat (2) cycle(0, 0, 0, 16'h0, 0, 1);
    // Reset in the middle of a discard, then reset while halted.
    cycle(0, 0, 1, 16'h0008, 0, 1);
    cycle(0, 0, 1, 16'h0040, 3, 1);
    cycle(1, 0, 0, 16'h0, 0, 1);
    repeat (2) cycle(0, 0, 0, 16'h0, 0, 1);
    cycle(0, 0, 1, 16'h000A, 0, 1);
    repeat (3) cycle(0, 0, 0, 16'h0, 0, 1);
    cycle(1, 0, 0, 16'h0, 0, 1);
    repeat (2) cycle(0, 0, 0, 16'h0, 0, 1);

    // Randomized traffic, including PC wrap via 0xFFFE targets.
    for (int n = 0; n < 3000; n++) begin
      tgt = ($urandom_range(0, 19) == 0) ? 16'hFFFE : {8'h00, 7'($urandom), 1'b0};
      cycle(bit'($urandom_range(0, 49) == 0), bit'($urandom_range(0, 3) == 0),
            bit'($urandom_range(0, 9) == 0), tgt, int'($urandom_range(0, 3)), 1);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drain", 35'(sb.size()), 35'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
